// File: rtl/keystone_pkg.sv
// rtl/keystone_pkg.sv - shared pixel types, packing offsets and pair packing for the keystone pixel path
package keystone_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef pixel_t [1:0] pixel_pair_t;

    localparam int G_LSB      = 2;
    localparam int B_LSB      = 12;
    localparam int R_LSB      = 22;
    localparam int PIX_STRIDE = 32;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Same layout the input parser unpacks: each colour sits in a 10-bit field, low two bits zero.
    function automatic logic [63:0] pack_pair(input pixel_pair_t pair);
        logic [63:0] word;
        word = '0;
        for (int p = 0; p < 2; p++) begin
            word[p*PIX_STRIDE + G_LSB +: 8] = pair[p].g;
            word[p*PIX_STRIDE + B_LSB +: 8] = pair[p].b;
            word[p*PIX_STRIDE + R_LSB +: 8] = pair[p].r;
        end
        return word;
    endfunction

endpackage

// File: rtl/keystone_stream_tx_if.sv
// rtl/keystone_stream_tx_if.sv - pixel-pair input channel and 64-bit video stream output of the transmitter
interface keystone_stream_tx_if;

    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  r0, g0, b0;
    logic [7:0]  r1, g1, b1;

    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tuser;
    logic        m_tlast;

    // master: the transmitter (pixel sink, stream source); slave: its environment
    modport master (
        input  pix_valid, r0, g0, b0, r1, g1, b1, m_tready,
        output pix_ready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

    modport slave (
        output pix_valid, r0, g0, b0, r1, g1, b1, m_tready,
        input  pix_ready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

endinterface

// File: rtl/keystone_sync_fifo.sv
// rtl/keystone_sync_fifo.sv - synchronous FIFO with async reset, sync flush and occupancy level
module keystone_sync_fifo #(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/keystone_stream_tx.sv
// rtl/keystone_stream_tx.sv - pixel pairs to 64-bit video stream with tuser/tlast; TX_TEST_PATTERN_EN adds a test pattern source
module keystone_stream_tx
    import keystone_pkg::*;
#(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
`ifdef TX_TEST_PATTERN_EN
    input  logic                         test_mode,
`endif
    keystone_stream_tx_if.master         io,
    output logic [15:0]                  frame_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam logic [15:0] X_LAST = 16'(WIDTH / 2 - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    out_state_t  state;
    logic        ready_en;
    logic [15:0] x_beat, y_line;
    logic [15:0] x_nx, y_nx;
    logic        frame_wrap;
    logic        handshake;
    logic        src_avail;
    logic        load;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    pixel_pair_t in_pair, fifo_pair, src_pair;
    logic [63:0] tdata_q;
    logic        tuser_q, tlast_q;

    assign in_pair   = {io.r1, io.g1, io.b1, io.r0, io.g0, io.b0};
    assign handshake = (state == OUT_FULL) && io.m_tready;
    assign load      = ((state == OUT_EMPTY) || handshake) && src_avail;
    assign fifo_push = io.pix_valid && io.pix_ready;

`ifdef TX_TEST_PATTERN_EN
    logic        pattern_mode;
    logic        use_pattern;
    logic [7:0]  x_even, x_odd;
    pixel_pair_t pattern_pair;

    // The source only changes on the beat that opens a frame.
    assign use_pattern  = (x_nx == '0 && y_nx == '0) ? test_mode : pattern_mode;
    assign x_even       = {x_nx[6:0], 1'b0};
    assign x_odd        = {x_nx[6:0], 1'b1};
    assign pattern_pair = {x_odd, y_nx[7:0], 8'hFF ^ x_odd, x_even, y_nx[7:0], 8'hFF ^ x_even};
    assign src_avail    = use_pattern || !fifo_empty;
    assign src_pair     = use_pattern ? pattern_pair : fifo_pair;
    assign fifo_pop     = load && !use_pattern && !frame_start;
    assign io.pix_ready = ready_en && !fifo_full && !frame_start && !test_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       pattern_mode <= 1'b0;
        else if (!frame_start && load) pattern_mode <= use_pattern;
    end
`else
    assign src_avail    = !fifo_empty;
    assign src_pair     = fifo_pair;
    assign fifo_pop     = load && !frame_start;
    assign io.pix_ready = ready_en && !fifo_full && !frame_start;
`endif

    keystone_sync_fifo #(
        .DATA_WIDTH ($bits(pixel_pair_t)),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (fifo_push),
        .wdata (in_pair),
        .pop   (fifo_pop),
        .rdata (fifo_pair),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Position of the beat that the next load will carry, after any handshake this cycle.
    always_comb begin
        x_nx       = x_beat;
        y_nx       = y_line;
        frame_wrap = 1'b0;
        if (handshake) begin
            if (x_beat == X_LAST) begin
                x_nx = '0;
                if (y_line == Y_LAST) begin
                    y_nx       = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nx = y_line + 16'd1;
                end
            end else begin
                x_nx = x_beat + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OUT_EMPTY;
            ready_en    <= 1'b0;
            x_beat      <= '0;
            y_line      <= '0;
            frame_count <= '0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (frame_start) begin
                state   <= OUT_EMPTY;
                x_beat  <= '0;
                y_line  <= '0;
                tdata_q <= '0;
                tuser_q <= 1'b0;
                tlast_q <= 1'b0;
            end else begin
                x_beat <= x_nx;
                y_line <= y_nx;
                if (frame_wrap) frame_count <= frame_count + 16'd1;
                if (load) begin
                    state   <= OUT_FULL;
                    tdata_q <= pack_pair(src_pair);
                    tuser_q <= (x_nx == '0) && (y_nx == '0);
                    tlast_q <= (x_nx == X_LAST);
                end else if (handshake) begin
                    state <= OUT_EMPTY;
                end
            end
        end
    end

    assign io.m_tvalid = (state == OUT_FULL);
    assign io.m_tdata  = tdata_q;
    assign io.m_tuser  = tuser_q;
    assign io.m_tlast  = tlast_q;

endmodule

// File: tb/tb_keystone_stream_tx.sv
// tb/tb_keystone_stream_tx.sv - scoreboard bench for keystone_stream_tx at WIDTH=8, HEIGHT=4, FIFO_DEPTH=4
module tb_keystone_stream_tx;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int D   = 4;
    localparam int BPL = W / 2;
    localparam int BPF = BPL * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] frame_count;
    logic [2:0]  fifo_level;

    keystone_stream_tx_if bus ();

    keystone_stream_tx #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
`ifdef TX_TEST_PATTERN_EN
        .test_mode   (1'b0),
`endif
        .io          (bus),
        .frame_count (frame_count),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_word;
    int          beat_mod = 0;
    logic [15:0] exp_fc = '0;
    int          push_cnt = 0;
    int          log_idx = 0;
    logic [63:0] user_log = '0;
    logic [63:0] last_log = '0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_user = 1'b0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Each pixel occupies 32 bits: {00, r, 00, b, 00, g, 00}
    function automatic logic [63:0] model_pack(input logic [7:0] r0, g0, b0, r1, g1, b1);
        return {2'b00, r1, 2'b00, b1, 2'b00, g1, 2'b00,
                2'b00, r0, 2'b00, b0, 2'b00, g0, 2'b00};
    endfunction

    // Scoreboard: every output handshake must carry the oldest outstanding accepted pair.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beat_mod   = 0;
            exp_fc     = '0;
            prev_stall = 1'b0;
        end else begin
            chk("occupancy", 64'(fifo_level) + 64'(bus.m_tvalid), 64'(exp_q.size()));
            chk("frame_count", 64'(frame_count), 64'(exp_fc));
            if (prev_stall) begin
                chk("hold_tvalid", 64'(bus.m_tvalid), 64'd1);
                chk("hold_tdata", bus.m_tdata, prev_data);
                chk("hold_tuser", 64'(bus.m_tuser), 64'(prev_user));
                chk("hold_tlast", 64'(bus.m_tlast), 64'(prev_last));
            end
            if (frame_start) begin
                exp_q.delete();
                beat_mod   = 0;
                prev_stall = 1'b0;
            end else begin
                if (bus.m_tvalid && bus.m_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_beat: got beat %h, expected no beat", bus.m_tdata);
                    end else begin
                        exp_word = exp_q.pop_front();
                        chk("tdata", bus.m_tdata, exp_word);
                        chk("tuser", 64'(bus.m_tuser), 64'(beat_mod == 0));
                        chk("tlast", 64'(bus.m_tlast), 64'(beat_mod % BPL == BPL - 1));
                        if (log_idx < 64) begin
                            user_log[log_idx] = bus.m_tuser;
                            last_log[log_idx] = bus.m_tlast;
                        end
                        log_idx++;
                        if (beat_mod == BPF - 1) exp_fc = exp_fc + 16'd1;
                        beat_mod = (beat_mod + 1) % BPF;
                    end
                end
                if (bus.pix_valid && bus.pix_ready) begin
                    exp_q.push_back(model_pack(bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1));
                    push_cnt++;
                end
                prev_stall = bus.m_tvalid && !bus.m_tready;
                prev_data  = bus.m_tdata;
                prev_user  = bus.m_tuser;
                prev_last  = bus.m_tlast;
            end
        end
    end

    task automatic rand_pix();
        bus.r0 = 8'($urandom); bus.g0 = 8'($urandom); bus.b0 = 8'($urandom);
        bus.r1 = 8'($urandom); bus.g1 = 8'($urandom); bus.b1 = 8'($urandom);
    endtask

    function automatic logic ready_pattern(input int rmode, input int cyc);
        case (rmode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (cyc % 2 == 0);
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic push_n(input int n, input int rmode);
        int target;
        int guard;
        target = push_cnt + n;
        guard  = 0;
        while (push_cnt < target && guard < 500) begin
            bus.pix_valid = 1'b1;
            rand_pix();
            bus.m_tready = ready_pattern(rmode, guard);
            @(posedge clk); #1;
            guard++;
        end
        bus.pix_valid = 1'b0;
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL push_timeout: got %0d pushes, expected %0d", push_cnt, target);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.pix_valid = 1'b0;
        bus.m_tready  = 1'b1;
        while ((exp_q.size() != 0 || bus.m_tvalid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    initial begin
        int guard;
        int push_base;
        logic [63:0] held;

        bus.pix_valid = 1'b0;
        bus.m_tready  = 1'b0;
        bus.r0 = '0; bus.g0 = '0; bus.b0 = '0;
        bus.r1 = '0; bus.g1 = '0; bus.b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("rst_tdata", bus.m_tdata, 64'd0);
        chk("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(bus.pix_ready), 64'd1);

        // Single pair: latency and packing
        bus.pix_valid = 1'b1;
        bus.m_tready  = 1'b1;
        bus.r0 = 8'hAB; bus.g0 = 8'h12; bus.b0 = 8'h34;
        bus.r1 = 8'h01; bus.g1 = 8'h02; bus.b1 = 8'h03;
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        chk("t1_not_yet_valid", 64'(bus.m_tvalid), 64'd0);
        @(posedge clk); #1;
        chk("t1_tvalid", 64'(bus.m_tvalid), 64'd1);
        chk("t1_tdata", bus.m_tdata, 64'h0040_3008_2AC3_4048);
        chk("t1_tuser", 64'(bus.m_tuser), 64'd1);
        chk("t1_tlast", 64'(bus.m_tlast), 64'd0);
        drain();

        // Full frame plus one beat, back to back
        pulse_frame_start();
        log_idx = 0; user_log = '0; last_log = '0;
        push_n(17, 1);
        drain();
        chk("t2_beats", 64'(log_idx), 64'd17);
        chk("t2_tlast_map", 64'(last_log[16:0]), 64'h0_8888);
        chk("t2_tuser_map", 64'(user_log[16:0]), 64'h1_0001);
        chk("t2_frame_count", 64'(frame_count), 64'd1);

        // Backpressure until full, then long stall
        push_base = push_cnt;
        bus.m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.pix_valid = 1'b1;
            rand_pix();
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        chk("t3_pix_ready", 64'(bus.pix_ready), 64'd0);
        chk("t3_level", 64'(fifo_level), 64'd4);
        chk("t3_tvalid", 64'(bus.m_tvalid), 64'd1);
        chk("t3_accepted", 64'(push_cnt - push_base), 64'd5);
        held = bus.m_tdata;
        repeat (10) @(posedge clk);
        #1;
        chk("t3_tdata_held", bus.m_tdata, held);
        log_idx = 0;
        drain();
        chk("t3_beats_out", 64'(log_idx), 64'd5);

        // Alternating ready, then fully random traffic
        push_n(40, 2);
        drain();
        for (int i = 0; i < 300; i++) begin
            bus.pix_valid = 1'($urandom);
            rand_pix();
            bus.m_tready = 1'($urandom);
            @(posedge clk); #1;
        end
        drain();

        // Resync mid-line while a beat is being accepted
        pulse_frame_start();
        guard = 0;
        bus.pix_valid = 1'b1;
        bus.m_tready  = 1'b1;
        while (!(bus.m_tvalid && beat_mod == BPL + 2) && guard < 200) begin
            rand_pix();
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL t5_reach_timeout: got beat %0d, expected %0d", beat_mod, BPL + 2);
        end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start   = 1'b0;
        bus.pix_valid = 1'b0;
        chk("t5_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("t5_level", 64'(fifo_level), 64'd0);
        chk("t5_frame_count", 64'(frame_count), 64'(exp_fc));
        log_idx = 0; user_log = '0;
        push_n(1, 1);
        drain();
        chk("t5_first_tuser", 64'(user_log[0]), 64'd1);

        // Asynchronous reset mid-frame
        push_n(20, 1);
        bus.m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.pix_valid = 1'b1;
            rand_pix();
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("t6_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("t6_tdata", bus.m_tdata, 64'd0);
        chk("t6_tuser", 64'(bus.m_tuser), 64'd0);
        chk("t6_tlast", 64'(bus.m_tlast), 64'd0);
        chk("t6_pix_ready", 64'(bus.pix_ready), 64'd0);
        chk("t6_level", 64'(fifo_level), 64'd0);
        chk("t6_frame_count", 64'(frame_count), 64'd0);
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready_after", 64'(bus.pix_ready), 64'd1);
        push_n(6, 3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
